// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : State, opcode and mux-select encodings for the multicycle MIPS control.
// Revision : 1.0
// ============================================================================
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_IEXEC    = 4'd9,
      S_JUMP     = 4'd10,
      S_JAL      = 4'd11,
      S_JR       = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_REGA   = 2'b11;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   localparam logic [1:0] ALUB_REGB  = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   typedef struct packed {
      logic       pc_we;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_re;
      logic       mem_we;
      logic       ir_we;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_we;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational next-state and output decode for multicycle_ctrl.
// Revision : 1.0
// ============================================================================
module ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic [5:0] i_opcode_q,
   input  logic [5:0] i_funct_q,
   input  logic       i_from_rtype,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctrl,
   output state_t     o_next
);

   logic [5:0] w_op;
   logic [5:0] w_fn;

   // Live IR only matters in DECODE; every later state uses the latched copy.
   assign w_op = (i_state == S_DECODE) ? i_opcode : i_opcode_q;
   assign w_fn = (i_state == S_DECODE) ? i_funct  : i_funct_q;

   always_comb begin
      o_ctrl = CTRL_IDLE;
      o_next = S_FETCH;
      case (i_state)
         S_FETCH: begin
            o_ctrl.mem_re    = 1'b1;
            o_ctrl.alu_src_b = ALUB_FOUR;
            o_ctrl.ir_we     = i_mem_ready;
            o_ctrl.pc_we     = i_mem_ready;
            o_next           = i_mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            o_ctrl.alu_src_b = ALUB_IMMSH;
            case (w_op)
               OP_LW, OP_SW:     o_next = S_MEMADR;
               OP_RTYPE:         o_next = (w_fn == FN_JR) ? S_JR : S_RTYPE_EX;
               OP_BEQ, OP_BNE:   o_next = S_BRANCH;
               OP_ADDI, OP_ORI:  o_next = S_IEXEC;
               OP_J:             o_next = S_JUMP;
               OP_JAL:           o_next = S_JAL;
               default: begin
                  o_next         = S_FETCH;
                  o_ctrl.illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ALUB_IMM;
            o_next           = (w_op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            o_ctrl.mem_re = 1'b1;
            o_ctrl.iord   = 1'b1;
            o_next        = i_mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            o_ctrl.reg_we     = 1'b1;
            o_ctrl.reg_dst    = REG_DST_RT;
            o_ctrl.mem_to_reg = M2R_MDR;
         end
         S_MEMWR: begin
            o_ctrl.mem_we = 1'b1;
            o_ctrl.iord   = 1'b1;
            o_next        = i_mem_ready ? S_FETCH : S_MEMWR;
         end
         S_RTYPE_EX: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ALUB_REGB;
            o_ctrl.alu_op    = ALUOP_FUNCT;
            o_next           = S_ALUWB;
         end
         S_ALUWB: begin
            o_ctrl.reg_we     = 1'b1;
            o_ctrl.mem_to_reg = M2R_ALUOUT;
            o_ctrl.reg_dst    = i_from_rtype ? REG_DST_RD : REG_DST_RT;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ALUB_REGB;
            o_ctrl.alu_op    = ALUOP_SUB;
            o_ctrl.pc_src    = PC_SRC_ALUOUT;
            o_ctrl.pc_we     = (w_op == OP_BNE) ? ~i_zero : i_zero;
         end
         S_IEXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ALUB_IMM;
            o_ctrl.alu_op    = (w_op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            o_next           = S_ALUWB;
         end
         S_JUMP: begin
            o_ctrl.pc_we  = 1'b1;
            o_ctrl.pc_src = PC_SRC_JUMP;
         end
         S_JAL: begin
            // PC already holds PC+4 here, so link and jump share one cycle.
            o_ctrl.reg_we     = 1'b1;
            o_ctrl.reg_dst    = REG_DST_RA;
            o_ctrl.mem_to_reg = M2R_PC;
            o_ctrl.pc_we      = 1'b1;
            o_ctrl.pc_src     = PC_SRC_JUMP;
         end
         S_JR: begin
            o_ctrl.pc_we  = 1'b1;
            o_ctrl.pc_src = PC_SRC_REGA;
         end
         default: begin
            o_ctrl = CTRL_IDLE;
            o_next = S_FETCH;
         end
      endcase
   end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle MIPS control FSM: state/decode-latch registers and outputs.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_re,
   output logic       mem_we,
   output logic       ir_we,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_we,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal,
   output logic [3:0] state
);

   state_t     r_state;
   logic [5:0] r_opcode;
   logic [5:0] r_funct;
   logic       r_from_rtype;

   state_t     w_next;
   ctrl_t      w_ctrl;
   ctrl_t      w_out;

   ctrl_decode u_decode (
      .i_state      (r_state),
      .i_opcode     (opcode),
      .i_funct      (funct),
      .i_opcode_q   (r_opcode),
      .i_funct_q    (r_funct),
      .i_from_rtype (r_from_rtype),
      .i_zero       (zero),
      .i_mem_ready  (mem_ready),
      .o_ctrl       (w_ctrl),
      .o_next       (w_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_FETCH;
         r_opcode     <= '0;
         r_funct      <= '0;
         r_from_rtype <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opcode     <= opcode;
            r_funct      <= funct;
            r_from_rtype <= (opcode == OP_RTYPE);
         end
      end
   end

   // FETCH would otherwise drive mem_re while reset is held.
   assign w_out = rst_n ? w_ctrl : CTRL_IDLE;

   assign pc_we      = w_out.pc_we;
   assign pc_src     = w_out.pc_src;
   assign iord       = w_out.iord;
   assign mem_re     = w_out.mem_re;
   assign mem_we     = w_out.mem_we;
   assign ir_we      = w_out.ir_we;
   assign reg_dst    = w_out.reg_dst;
   assign mem_to_reg = w_out.mem_to_reg;
   assign reg_we     = w_out.reg_we;
   assign alu_src_a  = w_out.alu_src_a;
   assign alu_src_b  = w_out.alu_src_b;
   assign alu_op     = w_out.alu_op;
   assign illegal    = w_out.illegal;
   assign state      = r_state;

endmodule : multicycle_ctrl
`default_nettype wire
